// File: rtl/half_life_pkg.sv
// Shared types and default widths for the half-life sequencer.
package half_life_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_e;

    localparam int N_DEF  = 4;
    localparam int QW_DEF = 8;
    localparam int HW_DEF = 4;

endpackage

// File: rtl/half_life_seq.sv
// Drives an external up/down/load counter to time half-life periods and halves
// a quantity register each time a period expires.
module half_life_seq
    import half_life_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int QW = QW_DEF,
    parameter int HW = HW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          clr,
    input  logic          pause,
    input  logic          tick,
    input  logic [N-1:0]  period,
    input  logic [QW-1:0] init_qty,
    input  logic [N-1:0]  cnt_out,
    output logic          cnt_rst,
    output logic          cnt_up,
    output logic          cnt_down,
    output logic          cnt_load,
    output logic [N-1:0]  cnt_in,
    output logic [QW-1:0] quantity,
    output logic [HW-1:0] halflives,
    output logic          busy,
    output logic          done
);

    state_e        state_q, state_d;
    logic [QW-1:0] quantity_q, quantity_d;
    logic [HW-1:0] halflives_q, halflives_d;
    logic [N-1:0]  per_q, per_d;
    logic [QW-1:0] qty_half;

    assign qty_half = quantity_q >> 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            quantity_q  <= '0;
            halflives_q <= '0;
            per_q       <= '0;
        end else begin
            state_q     <= state_d;
            quantity_q  <= quantity_d;
            halflives_q <= halflives_d;
            per_q       <= per_d;
        end
    end

    // The counter reload value is per_q-1 so that a reload at zero gives
    // exactly per_q ticks per half-life with no dead cycle.
    always_comb begin
        state_d     = state_q;
        quantity_d  = quantity_q;
        halflives_d = halflives_q;
        per_d       = per_q;
        cnt_down    = 1'b0;
        cnt_load    = 1'b0;
        cnt_in      = '0;

        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start && (period != '0)) begin
                        quantity_d  = init_qty;
                        halflives_d = '0;
                        per_d       = period;
                        state_d     = (init_qty == '0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    cnt_load = 1'b1;
                    cnt_in   = per_q - N'(1);
                    state_d  = RUN;
                end
                RUN: begin
                    if (!pause && tick) begin
                        if (cnt_out != '0) begin
                            cnt_down = 1'b1;
                        end else begin
                            cnt_load    = 1'b1;
                            cnt_in      = per_q - N'(1);
                            quantity_d  = qty_half;
                            halflives_d = (halflives_q == '1) ? halflives_q
                                                              : halflives_q + HW'(1);
                            if (qty_half == '0) begin
                                state_d = DONE;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign cnt_rst   = ~rst | clr;
    assign cnt_up    = 1'b0;
    assign quantity  = quantity_q;
    assign halflives = halflives_q;
    assign busy      = (state_q == LOAD) || (state_q == RUN);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_half_life_seq.sv
// Self-checking bench for half_life_seq with a behavioural model of the team counter.
module tb_half_life_seq;

    localparam int N  = 4;
    localparam int QW = 8;
    localparam int HW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          clr;
    logic          pause;
    logic          tick;
    logic [N-1:0]  period;
    logic [QW-1:0] init_qty;
    logic [N-1:0]  cnt_out;
    logic          cnt_rst;
    logic          cnt_up;
    logic          cnt_down;
    logic          cnt_load;
    logic [N-1:0]  cnt_in;
    logic [QW-1:0] quantity;
    logic [HW-1:0] halflives;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int q;
        int at;
    } exp_t;

    typedef struct {
        int period;
        int qty;
        int exp_hl;
        int exp_done;
        int pause_at;
        int pause_len;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];

    half_life_seq #(.N(N), .QW(QW), .HW(HW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .clr       (clr),
        .pause     (pause),
        .tick      (tick),
        .period    (period),
        .init_qty  (init_qty),
        .cnt_out   (cnt_out),
        .cnt_rst   (cnt_rst),
        .cnt_up    (cnt_up),
        .cnt_down  (cnt_down),
        .cnt_load  (cnt_load),
        .cnt_in    (cnt_in),
        .quantity  (quantity),
        .halflives (halflives),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Counter model: synchronous active-high reset, priority rst > up > down > load.
    always_ff @(posedge clk) begin
        if (cnt_rst)       cnt_out <= '0;
        else if (cnt_up)   cnt_out <= cnt_out + N'(1);
        else if (cnt_down) cnt_out <= cnt_out - N'(1);
        else if (cnt_load) cnt_out <= cnt_in;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int   q;
        int   k;
        int   s;
        int   act;
        int   q_prev;
        int   saved_cnt;
        int   saved_q;
        int   saved_hl;
        bit   was_paused;
        bit   paused;
        bit   seen_done;
        exp_t e;

        sb.delete();
        q = v.qty;
        k = 1;
        while (q != 0) begin
            q    = q >> 1;
            e.q  = q;
            e.at = 1 + v.period * k;
            sb.push_back(e);
            k++;
        end

        period   = N'(v.period);
        init_qty = QW'(v.qty);
        start    = 1'b1;
        tick     = 1'b1;
        pause    = 1'b0;
        clr      = 1'b0;
        step();
        start  = 1'b0;
        period = N'(v.period) ^ 4'h5;

        check("qty_loaded", int'(quantity), v.qty);
        check("load_after_start", int'(cnt_load), (v.qty != 0) ? 1 : 0);
        q_prev     = v.qty;
        act        = 0;
        s          = 0;
        was_paused = 1'b0;
        seen_done  = 1'b0;

        while (!seen_done && s < 400) begin
            if (was_paused) begin
                check("pause_cnt_frozen", int'(cnt_out), saved_cnt);
                check("pause_qty_hold", int'(quantity), saved_q);
                check("pause_hl_hold", int'(halflives), saved_hl);
            end
            if (int'(quantity) != q_prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_halving", int'(quantity), q_prev);
                end else begin
                    e = sb.pop_front();
                    check("halved_qty", int'(quantity), e.q);
                    check("halving_time", act, e.at);
                end
                q_prev = int'(quantity);
            end
            if (cnt_load) check("cnt_in_reload", int'(cnt_in), v.period - 1);
            if (cnt_up) check("cnt_up_zero", int'(cnt_up), 0);
            if (done) begin
                seen_done = 1'b1;
                check("done_cycle", s, v.exp_done);
                check("final_halflives", int'(halflives), v.exp_hl);
                check("final_qty", int'(quantity), 0);
                check("busy_in_done", int'(busy), 0);
                check("sb_drained", sb.size(), 0);
            end else begin
                check("busy_in_run", int'(busy), 1);
                paused = (s >= v.pause_at) && (s < v.pause_at + v.pause_len);
                pause  = paused;
                #1;
                if (paused) begin
                    check("pause_no_down", int'(cnt_down), 0);
                    check("pause_no_load", int'(cnt_load), 0);
                    saved_cnt = int'(cnt_out);
                    saved_q   = int'(quantity);
                    saved_hl  = int'(halflives);
                end else begin
                    act++;
                end
                was_paused = paused;
                step();
                s++;
            end
        end
        pause = 1'b0;
        if (!seen_done) check("done_timeout", 0, 1);
    endtask

    initial begin
        vecs[0] = '{4, 100, 7, 29, -1, 0};
        vecs[1] = '{1, 8, 4, 5, -1, 0};
        vecs[2] = '{3, 1, 1, 4, -1, 0};
        vecs[3] = '{15, 255, 8, 121, -1, 0};
        vecs[4] = '{2, 0, 0, 0, -1, 0};
        vecs[5] = '{7, 37, 6, 43, -1, 0};
        vecs[6] = '{4, 100, 7, 39, 6, 10};

        rst      = 1'b0;
        start    = 1'b0;
        clr      = 1'b0;
        pause    = 1'b0;
        tick     = 1'b0;
        period   = '0;
        init_qty = '0;

        step();
        step();
        check("rst_quantity", int'(quantity), 0);
        check("rst_halflives", int'(halflives), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_cnt_rst", int'(cnt_rst), 1);
        check("rst_cnt_out", int'(cnt_out), 0);
        rst = 1'b1;
        #1;
        check("cnt_rst_release", int'(cnt_rst), 0);
        step();

        // A zero period must leave the sequencer idle.
        period   = '0;
        init_qty = 8'd50;
        start    = 1'b1;
        tick     = 1'b1;
        step();
        start = 1'b0;
        check("p0_busy", int'(busy), 0);
        check("p0_done", int'(done), 0);
        check("p0_qty", int'(quantity), 0);
        step();
        check("p0_busy_later", int'(busy), 0);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
            step();
        end

        // Asynchronous reset in the middle of a run.
        period   = 4'd4;
        init_qty = 8'd100;
        start    = 1'b1;
        tick     = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        #2;
        rst = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_qty", int'(quantity), 0);
        check("midrst_hl", int'(halflives), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_cnt_rst", int'(cnt_rst), 1);
        step();
        check("midrst_cnt_out", int'(cnt_out), 0);
        rst = 1'b1;
        step();

        // clr beats a simultaneous start while running.
        period   = 4'd5;
        init_qty = 8'd200;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("pre_clr_qty", int'(quantity), 100);
        check("pre_clr_hl", int'(halflives), 1);
        clr   = 1'b1;
        start = 1'b1;
        #1;
        check("clr_cnt_rst", int'(cnt_rst), 1);
        check("clr_no_down", int'(cnt_down), 0);
        step();
        clr   = 1'b0;
        start = 1'b0;
        check("clr_busy", int'(busy), 0);
        check("clr_done", int'(done), 0);
        check("clr_qty_hold", int'(quantity), 100);
        check("clr_hl_hold", int'(halflives), 1);
        check("clr_cnt_out", int'(cnt_out), 0);
        step();
        check("clr_idle_later", int'(busy), 0);
        run_vec('{2, 4, 3, 7, -1, 0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/half_life_seq.md
Name: half_life_seq

Overview:
- Sequencer that drives the team's n-bit up/down/load counter (DFF-based, synchronous active-high rst, priority rst>up>down>load) and consumes its count value.
- Loads the half-life period into the counter, decrements it on prescaler ticks, and halves a quantity register each time a period expires.
- Reports elapsed half-lives and completion when the quantity reaches zero.
- Sits directly upstream of the counter; the counter is instantiated beside it at the timer top level.

Parameters:
- N, 4, counter width; must match the counter's n.
- QW, 8, quantity width.
- HW, 4, half-life count width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled in IDLE/DONE only.
- clr  in  1  synchronous abort to IDLE.
- pause  in  1  freeze run progress while high.
- tick  in  1  one-cycle prescaler enable; one count step per tick.
- period  in  N  ticks per half-life; valid 1..2^N-1.
- init_qty  in  QW  starting quantity.
- cnt_out  in  N  counter value fed back.
- cnt_rst  out  1  counter reset.
- cnt_up  out  1  counter up; tied 0.
- cnt_down  out  1  counter decrement.
- cnt_load  out  1  counter load.
- cnt_in  out  N  counter load value.
- quantity  out  QW  current quantity.
- halflives  out  HW  completed half-lives.
- busy  out  1  high in LOAD/RUN.
- done  out  1  high in DONE.

Behaviour:
- Reset (rst=0, async): state=IDLE, quantity=0, halflives=0, per_q=0, busy=0, done=0.
- cnt_rst is combinational: cnt_rst = ~rst | clr. It asserts while reset is held, so the counter clears on the next clk.
- Counter controls are combinational from state/inputs and are 0 in every case not listed below.
- cnt_up is always 0.
- States: IDLE, LOAD, RUN, DONE.
- Global priority: clr > pause > tick. clr in any state -> IDLE next cycle; quantity and halflives hold, done=0.
- IDLE / DONE, on start with clr=0:
  - period==0: start ignored, state unchanged.
  - else: quantity<=init_qty, halflives<=0, per_q<=period.
  - init_qty==0 -> DONE; else -> LOAD.
- LOAD: cnt_load=1, cnt_in=per_q-1. Always -> RUN. The counter shows per_q-1 the next cycle.
- RUN, pause=1: no controls asserted; state, quantity and halflives hold; ticks are dropped.
- RUN, tick=1 and cnt_out!=0: cnt_down=1.
- RUN, tick=1 and cnt_out==0 (period expired):
  - Same cycle: cnt_load=1, cnt_in=per_q-1.
  - quantity<=quantity>>1.
  - halflives<=halflives+1, saturating at 2^HW-1.
  - If quantity>>1==0 -> DONE (the load is still issued, harmless); else stay in RUN.
- Period timing: exactly per_q ticks per half-life with no dead cycles. The first half-life also includes the single LOAD cycle.
- Latency: the counter reflects a control one clk after it is driven. The FSM only acts on tick, so a tick in the cycle immediately after a down or load sees the updated cnt_out.
- start while busy: ignored.
- period changes mid-run: ignored; per_q is latched at start.
- DONE: done=1, outputs hold. start with period!=0 restarts directly.
- Width rules: cnt_in = per_q-1 in N bits (never underflows, since per_q>=1); quantity uses a logical shift.

Decomposition:
- Package half_life_pkg: state enum (IDLE, LOAD, RUN, DONE) and default widths N_DEF=4, QW_DEF=8, HW_DEF=4.
- No sub-module. The halving/counting datapath is small and stays in this file; the counter stays at the top level.

Test Plan:
- Nominal: bench instantiates the counter; period=4, init_qty=100, tick every cycle, start pulse.
  - cnt_load with cnt_in=3 one cycle after start.
  - quantity steps 100,50,25,12,6,3,1,0 every 4 ticks.
  - DONE with halflives=7, 28 ticks plus 1 LOAD cycle after start.
- Pause: pause=1 for 10 cycles mid-period with tick active.
  - cnt_down=0 throughout; cnt_out frozen; quantity/halflives unchanged.
  - Resumes exact remaining tick count after release.
- Edge inputs:
  - init_qty=0 with start -> DONE next cycle, halflives=0, no cnt_load.
  - period=0 with start -> remains IDLE, busy=0.
- period=1, init_qty=8:
  - Halves on every tick: 8,4,2,1,0.
  - halflives=4, cnt_in=0 on every load.
- Reset mid-run: rst=0 at arbitrary RUN cycle.
  - Immediately: state IDLE, quantity=0, halflives=0, busy=0, cnt_rst=1.
  - Counter reads 0 after next clk.
- clr precedence: clr=1 with start=1 in RUN.
  - IDLE next cycle, cnt_rst=1 that cycle, start ignored.
  - A later start restarts cleanly.
